// File: rtl/ice40_stage_sequencer_pkg.sv
// Shared definitions for the N-stage core sequencer: FSM state encoding
// and the width helper used to size the saturating counters.
package ice40_stage_sequencer_pkg;

    // state     | meaning
    // ST_INIT   | waiting for core init, model load and all stages idle
    // ST_IDLE   | no frame requested, core clock masked
    // ST_SEL    | choose the next enabled stage (skips disabled ones)
    // ST_RUN    | start raised, waiting for the stage to drop done
    // ST_WAIT_DONE | stage running, waiting for done to return high
    // ST_BUDGET | frame work finished, holding until the frame period elapses
    // ST_ERR    | one cycle after a watchdog expiry, then back to idle
    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SEL       = 3'd2,
        ST_RUN       = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_BUDGET    = 3'd5,
        ST_ERR       = 3'd6
    } seq_state_t;

    localparam int MAX_STAGES = 8;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ice40_stage_sequencer_sat_counter.sv
// Up-counter that clears on request and holds once it reaches MAX.
module ice40_sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == WIDTH'(MAX));

    // count up while enabled, sticking at MAX; clear has priority
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ice40_stage_sequencer.sv
// Frame sequencer for the gated processing core: after init it walks the
// enabled stages in order with a start/done handshake, enforces a minimum
// frame period and a per-stage watchdog, and gates the core clock in idle.
module ice40_stage_sequencer
    import ice40_stage_sequencer_pkg::*;
#(
    parameter int                    NUM_STAGES     = 2,
    parameter logic [NUM_STAGES-1:0] STAGE_EN       = {NUM_STAGES{1'b1}},
    parameter logic                  EN_CLKMASK     = 1'b1,
    parameter int                    BUDGET_CYCLES  = 0,
    parameter int                    TIMEOUT_CYCLES = 0
) (
    input  logic                  i_clk_in,
    input  logic                  resetn,
    input  logic                  i_init_done,
    input  logic                  i_load_done,
    input  logic                  i_active,
    input  logic [NUM_STAGES-1:0] i_done,
    output logic [NUM_STAGES-1:0] o_start,
    output logic                  o_clk_en,
    output logic                  o_init,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic [2:0]            o_err_stage,
    output logic                  o_overrun
);

    localparam int BUD_W  = cnt_width(BUDGET_CYCLES);
    localparam int BUD_M1 = (BUDGET_CYCLES > 0) ? BUDGET_CYCLES - 1 : 0;
    localparam int WD_W   = cnt_width(TIMEOUT_CYCLES);
    localparam int WD_M1  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);
    localparam logic [MAX_STAGES-1:0] EN_PAD = MAX_STAGES'(STAGE_EN);

    seq_state_t            state;
    logic [2:0]            idx;
    logic                  init_q;
    logic                  load_q;
    logic [NUM_STAGES-1:0] done_q;
    logic [MAX_STAGES-1:0] done_pad;
    logic [MAX_STAGES-1:0] start_oh;
    logic                  last_stage;

    logic             b_clr;
    logic [BUD_W-1:0] b_cnt;
    logic             b_at_max;
    logic             budget_met;
    logic             wd_clr;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_at_max;
    logic             wd_hit;

    assign done_pad   = MAX_STAGES'(done_q);
    assign start_oh   = MAX_STAGES'(1) << idx;
    assign last_stage = (idx == LAST_IDX);

    // Decisions use the registered count, so the current cycle is counted
    // by comparing against limit-1: the frame period lands exactly on budget
    // and the watchdog fires on the TIMEOUT_CYCLES-th running cycle.
    assign budget_met = b_at_max || (b_cnt == BUD_W'(BUD_M1));
    assign wd_hit     = (TIMEOUT_CYCLES != 0) && (wd_at_max || (wd_cnt == WD_W'(WD_M1)));

    assign b_clr  = (state inside {ST_INIT, ST_IDLE, ST_ERR}) || ((state == ST_BUDGET) && budget_met);
    assign wd_clr = !(state inside {ST_RUN, ST_WAIT_DONE});

    ice40_sat_counter #(.WIDTH(BUD_W), .MAX(BUDGET_CYCLES)) u_budget_cnt (
        .clk    (i_clk_in),
        .resetn (resetn),
        .clr    (b_clr),
        .en     (1'b1),
        .cnt    (b_cnt),
        .at_max (b_at_max)
    );

    ice40_sat_counter #(.WIDTH(WD_W), .MAX(TIMEOUT_CYCLES)) u_wd_cnt (
        .clk    (i_clk_in),
        .resetn (resetn),
        .clr    (wd_clr),
        .en     (1'b1),
        .cnt    (wd_cnt),
        .at_max (wd_at_max)
    );

    // sequencing FSM with input sync and all outputs registered
    always_ff @(posedge i_clk_in) begin
        if (!resetn) begin
            state       <= ST_INIT;
            idx         <= '0;
            init_q      <= 1'b0;
            load_q      <= 1'b0;
            done_q      <= '0;
            o_start     <= '0;
            o_clk_en    <= 1'b1;
            o_init      <= 1'b0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_stage <= '0;
            o_overrun   <= 1'b0;
        end else begin
            init_q    <= i_init_done;
            load_q    <= i_load_done;
            done_q    <= i_done;
            o_init    <= 1'b1;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
            o_busy    <= state inside {ST_SEL, ST_RUN, ST_WAIT_DONE, ST_BUDGET};
            o_clk_en  <= !EN_CLKMASK || (state != ST_IDLE);
            o_start   <= (state inside {ST_RUN, ST_WAIT_DONE}) ? start_oh[NUM_STAGES-1:0] : '0;
            case (state)
                ST_INIT: begin
                    if (init_q && load_q && (&done_q)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (i_active) begin
                        state <= ST_SEL;
                        idx   <= '0;
                    end
                end
                ST_SEL: begin
                    if (EN_PAD[idx]) state <= ST_RUN;
                    else if (last_stage) state <= ST_BUDGET;
                    else idx <= idx + 3'd1;
                end
                ST_RUN: begin
                    if (!done_pad[idx]) begin
                        state <= ST_WAIT_DONE;
                    end else if (wd_hit) begin
                        state       <= ST_ERR;
                        o_start     <= '0;
                        o_timeout   <= 1'b1;
                        o_err_stage <= idx;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_pad[idx]) begin
                        if (last_stage) begin
                            state     <= ST_BUDGET;
                            o_overrun <= (BUDGET_CYCLES != 0) && budget_met;
                        end else begin
                            state <= ST_SEL;
                            idx   <= idx + 3'd1;
                        end
                    end else if (wd_hit) begin
                        state       <= ST_ERR;
                        o_start     <= '0;
                        o_timeout   <= 1'b1;
                        o_err_stage <= idx;
                    end
                end
                ST_BUDGET: begin
                    if (budget_met) begin
                        if (i_active) begin
                            state <= ST_SEL;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: state <= ST_IDLE;
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ice40_stage_sequencer.sv
// Directed bench for the stage sequencer: three instances cover the plain
// three-stage flow, the watchdog, and stage skipping with a frame budget.
module tb_ice40_stage_sequencer;

    localparam logic [2:0] EN_P  [3] = '{3'b111, 3'b111, 3'b101};
    localparam int         BUD_P [3] = '{0, 0, 200};
    localparam int         TO_P  [3] = '{0, 50, 0};

    logic       clk = 1'b0;
    logic       resetn;
    logic       init_done;
    logic       load_done;
    logic       active    [3];
    logic [2:0] start_o   [3];
    logic       clk_en_o  [3];
    logic       init_o    [3];
    logic       busy_o    [3];
    logic       timeout_o [3];
    logic [2:0] err_o     [3];
    logic       overrun_o [3];

    int hold_len [3][3];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    logic seen_s1 = 1'b0;
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    // cycle stamp used for all latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // watch instance 2 for overrun pulses and any start of the disabled stage
    always @(negedge clk) begin
        if (overrun_o[2]) ovr_cnt <= ovr_cnt + 1;
        if (start_o[2][1]) seen_s1 <= 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] done_l;

        ice40_stage_sequencer #(
            .NUM_STAGES     (3),
            .STAGE_EN       (EN_P[g]),
            .EN_CLKMASK     (1'b1),
            .BUDGET_CYCLES  (BUD_P[g]),
            .TIMEOUT_CYCLES (TO_P[g])
        ) dut (
            .i_clk_in    (clk),
            .resetn      (resetn),
            .i_init_done (init_done),
            .i_load_done (load_done),
            .i_active    (active[g]),
            .i_done      (done_l),
            .o_start     (start_o[g]),
            .o_clk_en    (clk_en_o[g]),
            .o_init      (init_o[g]),
            .o_busy      (busy_o[g]),
            .o_timeout   (timeout_o[g]),
            .o_err_stage (err_o[g]),
            .o_overrun   (overrun_o[g])
        );

        // stage model: drop done 2 cycles after start, raise it hold_len later
        // (hold_len of 0 means the stage hangs)
        initial begin : resp
            int h;
            int k;
            done_l = 3'b111;
            forever begin
                @(posedge clk); #1;
                if (start_o[g] != 3'b000) begin
                    k = start_o[g][2] ? 2 : (start_o[g][1] ? 1 : 0);
                    h = hold_len[g][k];
                    repeat (2) @(posedge clk);
                    #1 done_l[k] = 1'b0;
                    if (h > 0) begin
                        repeat (h) @(posedge clk);
                        #1 done_l[k] = 1'b1;
                    end
                    while (start_o[g] != 3'b000) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [2:0] v);
        logic [2:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        chk(tag, int'(v), int'(e));
    endtask

    task automatic wait_new_start(input int i, input int limit, output logic [2:0] v, output int t);
        logic [2:0] last;
        last = start_o[i];
        v = 3'b000;
        t = -1;
        for (int n = 0; n < limit; n++) begin
            @(posedge clk); #1;
            if (start_o[i] != 3'b000 && start_o[i] != last) begin
                v = start_o[i];
                t = cyc;
                break;
            end
            last = start_o[i];
        end
    endtask

    task automatic wait_pulse_timeout(input int i, input int limit, output int t);
        t = -1;
        for (int n = 0; n < limit; n++) begin
            tick(1);
            if (timeout_o[i]) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_pulse_overrun(input int i, input int limit, output int t);
        t = -1;
        for (int n = 0; n < limit; n++) begin
            tick(1);
            if (overrun_o[i]) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin : main
        logic [2:0] v;
        int t0, t1, t2, t3;

        resetn    = 1'b0;
        init_done = 1'b0;
        load_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0;
            for (int k = 0; k < 3; k++) hold_len[i][k] = 10;
        end
        tick(3);

        chk("rst_init", int'(init_o[0]), 0);
        chk("rst_clk_en", int'(clk_en_o[0]), 1);
        chk("rst_start", int'(start_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_err_stage", int'(err_o[0]), 0);
        chk("rst_timeout", int'(timeout_o[0]), 0);

        // init handshake: no load yet keeps the core clocked in INIT
        resetn    = 1'b1;
        init_done = 1'b1;
        tick(1);
        chk("init_after_release", int'(init_o[0]), 1);
        tick(8);
        chk("init_wait_clk_en", int'(clk_en_o[0]), 1);
        chk("init_wait_busy", int'(busy_o[0]), 0);
        load_done = 1'b1;
        tick(2);
        chk("idle_edge2_clk_en", int'(clk_en_o[0]), 1);
        tick(1);
        for (int i = 0; i < 3; i++) chk($sformatf("idle_edge3_clk_en%0d", i), int'(clk_en_o[i]), 0);

        // three stages in order, 16-cycle spacing for hold of 10
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        t0 = cyc;
        active[0] = 1'b1;
        tick(1);
        chk("frame_clk_en_lag", int'(clk_en_o[0]), 0);
        tick(1);
        chk("frame_clk_en_on", int'(clk_en_o[0]), 1);
        wait_new_start(0, 40, v, t1);
        sb_chk("t2_start0", v);
        chk("t2_first_latency", t1 - t0, 3);
        chk("t2_busy", int'(busy_o[0]), 1);
        wait_new_start(0, 40, v, t2);
        sb_chk("t2_start1", v);
        chk("t2_gap01", t2 - t1, 16);
        wait_new_start(0, 40, v, t3);
        sb_chk("t2_start2", v);
        chk("t2_gap12", t3 - t2, 16);
        active[0] = 1'b0;
        tick(15);
        chk("t2_busy_in_budget", int'(busy_o[0]), 1);
        chk("t2_start_cleared", int'(start_o[0]), 0);
        tick(1);
        chk("t2_busy_idle", int'(busy_o[0]), 0);
        chk("t2_clk_en_idle", int'(clk_en_o[0]), 0);

        // watchdog: stage 1 never returns done
        hold_len[1][0] = 5;
        hold_len[1][1] = 0;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        active[1] = 1'b1;
        wait_new_start(1, 40, v, t1);
        sb_chk("t4_start0", v);
        wait_new_start(1, 40, v, t2);
        sb_chk("t4_start1", v);
        chk("t4_gap01", t2 - t1, 11);
        active[1] = 1'b0;
        wait_pulse_timeout(1, 80, t3);
        chk("t4_timeout_at", t3 - t2, 49);
        chk("t4_err_stage", int'(err_o[1]), 1);
        chk("t4_start_off", int'(start_o[1]), 0);
        tick(1);
        chk("t4_timeout_pulse", int'(timeout_o[1]), 0);
        chk("t4_busy_err", int'(busy_o[1]), 0);
        tick(1);
        chk("t4_clk_en_idle", int'(clk_en_o[1]), 0);
        chk("t4_err_stage_held", int'(err_o[1]), 1);

        // skipped stage 1, then 200-cycle frame budget and an overrun
        hold_len[2][0] = 20;
        hold_len[2][2] = 20;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b100);
        active[2] = 1'b1;
        wait_new_start(2, 40, v, t0);
        sb_chk("t3_start0", v);
        wait_new_start(2, 60, v, t1);
        sb_chk("t3_start2", v);
        chk("t3_gap02", t1 - t0, 27);
        tick(3);
        hold_len[2][0] = 120;
        hold_len[2][2] = 120;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b100);
        wait_new_start(2, 250, v, t2);
        sb_chk("t5_start0_f2", v);
        chk("t5_period", t2 - t0, 200);
        chk("t5_no_overrun_f1", ovr_cnt, 0);
        wait_new_start(2, 200, v, t3);
        sb_chk("t5_start2_f2", v);
        chk("t5_gap02_long", t3 - t2, 127);
        active[2] = 1'b0;
        wait_pulse_overrun(2, 200, t1);
        chk("t5_overrun_at", t1 - t3, 124);
        tick(1);
        chk("t5_overrun_pulse", int'(overrun_o[2]), 0);
        tick(1);
        chk("t5_busy_idle", int'(busy_o[2]), 0);
        chk("t5_overrun_count", ovr_cnt, 1);
        chk("t3_stage1_never", int'(seen_s1), 0);

        // reset while stage 1 is running
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        active[0] = 1'b1;
        wait_new_start(0, 40, v, t1);
        sb_chk("t6_start0", v);
        wait_new_start(0, 40, v, t2);
        sb_chk("t6_start1", v);
        tick(6);
        chk("t6_pre_busy", int'(busy_o[0]), 1);
        resetn = 1'b0;
        active[0] = 1'b0;
        tick(1);
        chk("t6_start", int'(start_o[0]), 0);
        chk("t6_busy", int'(busy_o[0]), 0);
        chk("t6_init", int'(init_o[0]), 0);
        chk("t6_clk_en", int'(clk_en_o[0]), 1);
        chk("t6_timeout", int'(timeout_o[0]), 0);
        resetn = 1'b1;
        tick(3);
        chk("t6_busy_after", int'(busy_o[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
